// File: rtl/i2c_pkg.sv
// i2c_pkg: state encodings and line-level constants shared by the I2C controller and responder
package i2c_pkg;
  typedef enum logic [3:0] {
    ST_IDLE, ST_DEV_ADDR, ST_ACK_DEV, ST_WORD_ADDR, ST_ACK_WORD,
    ST_WR_DATA, ST_ACK_WR, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
  } i2c_state_e;
  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'b1010110;
  // {previous, current} synchronized SDA while SCL is held high
  localparam logic [1:0] SDA_START = 2'b10;
  localparam logic [1:0] SDA_STOP  = 2'b01;
  localparam logic       ACK       = 1'b0;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: two-flop synchronizers on SCL/SDA with SCL edge and START/STOP strobes
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  // bits [1:0] synchronize, bit [2] holds the previous synchronized value
  logic [2:0] scl_q, sda_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end
  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = scl_q[1] & scl_q[2] & (sda_q[2:1] == SDA_START);
  assign stop_o     = scl_q[1] & scl_q[2] & (sda_q[2:1] == SDA_STOP);
endmodule

// File: rtl/i2c_eeprom_responder.sv
// i2c_eeprom_responder: EEPROM-style I2C target with an auto-incrementing 8-bit word pointer
module i2c_eeprom_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEFAULT,
  parameter int         MEM_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       busy,
  output logic       wr_pulse,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);
  logic       sda_s, scl_rise, scl_fall, start, stop;
  i2c_state_e state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shreg_q, ptr_q;
  logic       rw_q, sda_oe_q;
  logic [7:0] mem [MEM_DEPTH];
  logic [7:0] rx_byte;
  logic       byte_done;
  logic [2:0] rd_idx;

  i2c_line_sync u_sync (
    .clk(clk), .rst_n(rst_n), .scl_i(SCL), .sda_i(SDA), .sda_o(sda_s),
    .scl_rise_o(scl_rise), .scl_fall_o(scl_fall), .start_o(start), .stop_o(stop)
  );

  assign rx_byte   = {shreg_q[6:0], sda_s};
  assign byte_done = scl_rise && bit_cnt_q == 4'd7;
  assign rd_idx    = 3'd7 - bit_cnt_q[2:0];
  assign SDA       = sda_oe_q ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (state_q == ST_WR_DATA && byte_done) mem[ptr_q] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy      <= 1'b0;
      wr_pulse  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_pulse <= 1'b0;
      if (stop) begin
        state_q  <= ST_IDLE;
        sda_oe_q <= 1'b0;
        busy     <= 1'b0;
      end else if (start) begin
        state_q   <= ST_DEV_ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_DEV_ADDR, ST_WORD_ADDR, ST_WR_DATA: begin
            // the first fall of a received byte also ends the preceding ACK
            if (scl_fall) sda_oe_q <= 1'b0;
            if (scl_rise) begin
              shreg_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (byte_done) begin
              bit_cnt_q <= '0;
              case (state_q)
                ST_DEV_ADDR: begin
                  state_q <= rx_byte[7:1] == DEV_ADDR ? ST_ACK_DEV : ST_IGNORE;
                  busy    <= rx_byte[7:1] == DEV_ADDR;
                  rw_q    <= rx_byte[0];
                end
                ST_WORD_ADDR: begin
                  state_q <= ST_ACK_WORD;
                  ptr_q   <= rx_byte;
                end
                default: begin
                  state_q  <= ST_ACK_WR;
                  ptr_q    <= ptr_q + 8'd1;
                  wr_pulse <= 1'b1;
                  wr_addr  <= ptr_q;
                  wr_data  <= rx_byte;
                end
              endcase
            end
          end
          ST_ACK_DEV, ST_ACK_WORD, ST_ACK_WR: begin
            if (scl_fall) sda_oe_q <= 1'b1;
            if (scl_rise) state_q <= state_q == ST_ACK_DEV ? (rw_q ? ST_RD_DATA : ST_WORD_ADDR) : ST_WR_DATA;
          end
          ST_RD_DATA: begin
            if (scl_fall) begin
              sda_oe_q  <= bit_cnt_q[3] ? 1'b0 : ~mem[ptr_q][rd_idx];
              bit_cnt_q <= bit_cnt_q[3] ? 4'd0 : bit_cnt_q + 4'd1;
              if (bit_cnt_q[3]) state_q <= ST_RD_ACK;
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              ptr_q   <= ptr_q + 8'd1;
              state_q <= sda_s == ACK ? ST_RD_DATA : ST_IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_eeprom_responder.sv
// tb_i2c_eeprom_responder: bit-banged I2C controller checking the responder against a byte-level memory model
module tb_i2c_eeprom_responder;
  localparam int Q = 80;
  logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, drv_low = 1'b0;
  wire sda_bus;
  logic busy, wr_pulse;
  logic [7:0] wr_addr, wr_data;
  int total = 0, bad = 0;
  logic [7:0] model_mem [256];
  bit model_ok [256];
  logic [7:0] model_ptr = 8'h00;
  logic [7:0] ev_addr[$], ev_data[$];

  typedef struct {
    logic [7:0] ab;
    logic       exp_nak;
    logic       exp_busy;
  } addr_vec_t;
  addr_vec_t tv [6];

  assign sda_bus = drv_low ? 1'b0 : 1'bz;
  pullup (sda_bus);
  always #5 clk = ~clk;

  i2c_eeprom_responder dut (
    .clk(clk), .rst_n(rst_n), .SCL(scl), .SDA(sda_bus),
    .busy(busy), .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always @(negedge clk) if (wr_pulse) begin
    ev_addr.push_back(wr_addr);
    ev_data.push_back(wr_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    drv_low = ~b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
    #Q;
  endtask

  task automatic bit_in(output logic b);
    drv_low = 1'b0;
    #Q scl = 1'b1;
    #Q b = sda_bus;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    drv_low = 1'b0;
    #Q scl = 1'b1;
    #Q drv_low = 1'b1;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    drv_low = 1'b1;
    #Q scl = 1'b1;
    #Q drv_low = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic nak);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    bit_in(nak);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nak);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      bit_in(x);
      b[i] = x;
    end
    bit_out(nak);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d[$]);
    logic nak;
    ev_addr.delete();
    ev_data.delete();
    i2c_start();
    send_byte(8'hAC, nak);
    chk("wr dev ack", nak, 0);
    send_byte(a, nak);
    chk("wr word ack", nak, 0);
    foreach (d[i]) begin
      send_byte(d[i], nak);
      chk("wr data ack", nak, 0);
    end
    i2c_stop();
    chk("wr pulse count", ev_addr.size(), d.size());
    model_ptr = a;
    foreach (d[i]) begin
      if (i < ev_addr.size()) begin
        chk("wr_addr", ev_addr[i], model_ptr);
        chk("wr_data", ev_data[i], d[i]);
      end
      model_mem[model_ptr] = d[i];
      model_ok[model_ptr] = 1'b1;
      model_ptr++;
    end
  endtask

  task automatic do_read(input logic set_addr, input logic [7:0] a, input int n);
    logic nak;
    logic [7:0] b;
    ev_addr.delete();
    i2c_start();
    if (set_addr) begin
      send_byte(8'hAC, nak);
      send_byte(a, nak);
      chk("rd word ack", nak, 0);
      i2c_start();
      model_ptr = a;
    end
    send_byte(8'hAD, nak);
    chk("rd dev ack", nak, 0);
    for (int i = 0; i < n; i++) begin
      recv_byte(b, i == n - 1);
      if (model_ok[model_ptr]) chk("rd data", b, model_mem[model_ptr]);
      model_ptr++;
    end
    i2c_stop();
    chk("rd no wr pulse", ev_addr.size(), 0);
  endtask

  initial begin
    logic nak;
    logic [7:0] b;
    logic [7:0] dq[$];
    tv[0] = '{8'hAC, 1'b0, 1'b1};
    tv[1] = '{8'hAD, 1'b0, 1'b1};
    tv[2] = '{8'hA0, 1'b1, 1'b0};
    tv[3] = '{8'hAE, 1'b1, 1'b0};
    tv[4] = '{8'h2C, 1'b1, 1'b0};
    tv[5] = '{8'hED, 1'b1, 1'b0};

    #(4*Q);
    chk("rst busy", busy, 0);
    chk("rst wr_pulse", wr_pulse, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst sda", sda_bus, 1);
    rst_n = 1'b1;
    #(2*Q);

    foreach (tv[k]) begin
      ev_addr.delete();
      i2c_start();
      send_byte(tv[k].ab, nak);
      chk("addr ack", nak, tv[k].exp_nak);
      chk("addr busy", busy, tv[k].exp_busy);
      if (!nak && tv[k].ab[0]) begin
        recv_byte(b, 1'b1);
        if (model_ok[model_ptr]) chk("addr rd data", b, model_mem[model_ptr]);
        model_ptr++;
      end else if (nak) begin
        send_byte(8'h10, nak);
        chk("ignored byte ack", nak, 1);
        send_byte(8'h55, nak);
        chk("ignored byte ack", nak, 1);
        chk("ignored busy", busy, 0);
      end
      i2c_stop();
      chk("addr pulses", ev_addr.size(), 0);
      chk("stop busy", busy, 0);
    end

    dq = {8'h5A};
    do_write(8'h10, dq);
    dq = {8'h3C, 8'hC3};
    do_write(8'h11, dq);
    dq.delete();
    do_write(8'h10, dq);
    do_read(1'b0, 8'h00, 2);
    do_read(1'b0, 8'h00, 1);

    dq = {8'h01, 8'h02};
    do_write(8'hFF, dq);
    do_read(1'b1, 8'hFF, 2);

    dq = {8'h99};
    do_write(8'h20, dq);
    ev_addr.delete();
    i2c_start();
    send_byte(8'hAC, nak);
    send_byte(8'h20, nak);
    bit_out(1'b0); bit_out(1'b1); bit_out(1'b1); bit_out(1'b0);
    i2c_stop();
    chk("partial no pulse", ev_addr.size(), 0);
    chk("partial busy", busy, 0);
    do_read(1'b1, 8'h20, 1);

    for (int r = 0; r < 24; r++) begin
      logic [7:0] a;
      a = 8'h40 + 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        dq.delete();
        for (int j = 0; j < int'($urandom_range(1, 4)); j++) dq.push_back(8'($urandom));
        do_write(a, dq);
      end else begin
        do_read(1'($urandom_range(0, 1)), a, int'($urandom_range(1, 3)));
      end
    end

    i2c_start();
    send_byte(8'hAC, nak);
    send_byte(8'h10, nak);
    i2c_start();
    send_byte(8'hAD, nak);
    chk("mid-read ack", nak, 0);
    chk("mid-read sda driven", sda_bus, 0);
    chk("mid-read busy", busy, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst sda", sda_bus, 1);
    chk("async rst busy", busy, 0);
    chk("async rst wr_pulse", wr_pulse, 0);
    chk("async rst wr_addr", wr_addr, 0);
    chk("async rst wr_data", wr_data, 0);
    drv_low = 1'b0;
    scl = 1'b1;
    #(2*Q) rst_n = 1'b1;
    model_ptr = 8'h00;
    #(2*Q);
    do_read(1'b1, 8'h10, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
